sobel_3x3_gray8: RTL and testbench

Streaming 3x3 Sobel edge detector for 8-bit grayscale pixels. It sits directly downstream of the 3x3 Gaussian blur stage and consumes its `pixel_out`/`filter_ready` stream. It keeps two internal line buffers so that true vertical neighbours are used. It emits, per accepted pixel, a saturated gradient magnitude and a thresholded binary edge flag for the display/VGA path.

---
 rtl/sobel_3x3_gray8.sv | 230 +++++++++++++++++++++++
 tb/tb_sobel_3x3_gray8.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_3x3_gray8.sv
// sobel_3x3_gray8: streaming 3x3 Sobel edge detector for 8-bit grayscale.
// Two line buffers supply true vertical neighbours. A three-stage pipeline
// (window, gradients, magnitude/threshold) emits one result per accepted pixel.
module sobel_3x3_gray8 #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] pixel_in,
  input  logic       pixel_valid,
  input  logic       vsync,
  input  logic [7:0] threshold,
  output logic [7:0] edge_out,
  output logic       edge_bin,
  output logic       edge_valid,
  output logic       frame_done
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned GRAD_W = 11;
  localparam int unsigned COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [GRAD_W-1:0] SAT_MAX  = GRAD_W'(255);

  // Frame position and sync tracking
  logic             r_vsync_prev;
  logic             r_frame_full;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_vsync_rise;
  logic             w_accept;
  logic             w_col_last;
  logic             w_row_last;
  logic             w_border;

  // Line buffers: LB0 = previous row, LB1 = row before that
  logic [PIX_W-1:0] r_lb0 [IMG_WIDTH];
  logic [PIX_W-1:0] r_lb1 [IMG_WIDTH];
  logic [PIX_W-1:0] w_lb0_rd;
  logic [PIX_W-1:0] w_lb1_rd;

  // 3x3 window, r_win[y][x], y=0 top row, x=2 newest column
  logic [PIX_W-1:0] r_win [3][3];

  // Stage 1 side-band
  logic r_s1_valid;
  logic r_s1_border;
  logic r_s1_last;

  // Stage 2 gradients (two's complement)
  logic [GRAD_W-1:0] w_gx;
  logic [GRAD_W-1:0] w_gy;
  logic [GRAD_W-1:0] r_s2_gx;
  logic [GRAD_W-1:0] r_s2_gy;
  logic              r_s2_valid;
  logic              r_s2_border;
  logic              r_s2_last;

  // Stage 3 magnitude
  logic [GRAD_W-1:0] w_abs_gx;
  logic [GRAD_W-1:0] w_abs_gy;
  logic [GRAD_W-1:0] w_mag;
  logic [PIX_W-1:0]  w_sat;
  logic              w_bin;

  // a + 2b + c, zero-extended into the gradient width
  function automatic logic [GRAD_W-1:0] f_wsum(input logic [PIX_W-1:0] a,
                                               input logic [PIX_W-1:0] b,
                                               input logic [PIX_W-1:0] c);
    return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
  endfunction

  assign w_vsync_rise = vsync & ~r_vsync_prev;
  assign w_accept     = enable & pixel_valid & ~w_vsync_rise & ~r_frame_full;
  assign w_col_last   = (r_col == COL_LAST);
  assign w_row_last   = (r_row == ROW_LAST);
  assign w_border     = (r_row < ROW_W'(2)) | (r_col < COL_W'(2));
  assign w_lb0_rd     = r_lb0[r_col];
  assign w_lb1_rd     = r_lb1[r_col];

  // Sync edge detector; tracked every cycle so a sync is not lost while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vsync_prev <= 1'b0;
    end else begin
      r_vsync_prev <= vsync;
    end
  end

  // Raster counters and end-of-frame latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row        <= '0;
      r_col        <= '0;
      r_frame_full <= 1'b0;
    end else if (w_vsync_rise) begin
      r_row        <= '0;
      r_col        <= '0;
      r_frame_full <= 1'b0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        if (w_row_last) begin
          r_row        <= '0;
          r_frame_full <= 1'b1;
        end else begin
          r_row <= r_row + ROW_W'(1);
        end
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Line buffer update; reads above see pre-write contents
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= w_lb0_rd;
      r_lb0[r_col] <= pixel_in;
    end
  end

  // Shift window: new column {LB1, LB0, pixel_in} enters at x=2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int y = 0; y < 3; y++) begin
        for (int x = 0; x < 3; x++) begin
          r_win[y][x] <= '0;
        end
      end
    end else if (w_vsync_rise) begin
      for (int y = 0; y < 3; y++) begin
        for (int x = 0; x < 3; x++) begin
          r_win[y][x] <= '0;
        end
      end
    end else if (w_accept) begin
      for (int y = 0; y < 3; y++) begin
        r_win[y][0] <= r_win[y][1];
        r_win[y][1] <= r_win[y][2];
      end
      r_win[0][2] <= w_lb1_rd;
      r_win[1][2] <= w_lb0_rd;
      r_win[2][2] <= pixel_in;
    end
  end

  // Stage 1 side-band: validity, border mask and last-pixel tag of the accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_last   <= 1'b0;
    end else if (w_vsync_rise) begin
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_last   <= 1'b0;
    end else if (enable) begin
      r_s1_valid  <= w_accept;
      r_s1_border <= w_border;
      r_s1_last   <= w_col_last & w_row_last;
    end
  end

  // Sobel gradients from the current window
  always_comb begin
    w_gx = f_wsum(r_win[0][2], r_win[1][2], r_win[2][2])
         - f_wsum(r_win[0][0], r_win[1][0], r_win[2][0]);
    w_gy = f_wsum(r_win[2][0], r_win[2][1], r_win[2][2])
         - f_wsum(r_win[0][0], r_win[0][1], r_win[0][2]);
  end

  // Stage 2: register gradients and side-band
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_gx     <= '0;
      r_s2_gy     <= '0;
      r_s2_valid  <= 1'b0;
      r_s2_border <= 1'b0;
      r_s2_last   <= 1'b0;
    end else if (w_vsync_rise) begin
      r_s2_valid  <= 1'b0;
      r_s2_last   <= 1'b0;
    end else if (enable) begin
      r_s2_gx     <= w_gx;
      r_s2_gy     <= w_gy;
      r_s2_valid  <= r_s1_valid;
      r_s2_border <= r_s1_border;
      r_s2_last   <= r_s1_last;
    end
  end

  // |Gx| + |Gy|, saturated to 8 bits, then thresholded
  always_comb begin
    w_abs_gx = r_s2_gx[GRAD_W-1] ? (~r_s2_gx + GRAD_W'(1)) : r_s2_gx;
    w_abs_gy = r_s2_gy[GRAD_W-1] ? (~r_s2_gy + GRAD_W'(1)) : r_s2_gy;
    w_mag    = w_abs_gx + w_abs_gy;
    w_sat    = (w_mag > SAT_MAX) ? 8'hFF : w_mag[PIX_W-1:0];
    w_bin    = (w_sat >= threshold);
  end

  // Stage 3: registered outputs; border pixels report zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_out   <= '0;
      edge_bin   <= 1'b0;
      edge_valid <= 1'b0;
      frame_done <= 1'b0;
    end else if (w_vsync_rise) begin
      edge_out   <= '0;
      edge_bin   <= 1'b0;
      edge_valid <= 1'b0;
      frame_done <= 1'b0;
    end else if (enable) begin
      edge_out   <= (r_s2_valid & ~r_s2_border) ? w_sat : '0;
      edge_bin   <= r_s2_valid & ~r_s2_border & w_bin;
      edge_valid <= r_s2_valid;
      frame_done <= r_s2_valid & r_s2_last;
    end else begin
      edge_valid <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_3x3_gray8.sv
// tb_sobel_3x3_gray8: directed bench for the Sobel stage on a reduced 8x4 frame.
// A small reference model predicts every result and the enabled cycle it appears in.
module tb_sobel_3x3_gray8;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int SPLIT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       vsync;
  logic [7:0] threshold;
  logic [7:0] edge_out;
  logic       edge_bin;
  logic       edge_valid;
  logic       frame_done;

  sobel_3x3_gray8 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pixel_in   (pixel_in),
    .pixel_valid(pixel_valid),
    .vsync      (vsync),
    .threshold  (threshold),
    .edge_out   (edge_out),
    .edge_bin   (edge_bin),
    .edge_valid (edge_valid),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       bin;
    logic       fd;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_row, m_col, ena_cnt;
  logic m_full, m_vprev;
  int   img_mode, lo, hi, thr;
  int   n_res, n_sat, n_fd, n_bin, n_40, n_200;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int pxv(input int r, input int c);
    if (img_mode == 0) return (c >= SPLIT) ? hi : lo;
    return (r >= 2) ? hi : lo;
  endfunction

  function automatic int exp_mag(input int r, input int c);
    int p[3][3];
    int gx, gy, m;
    if (r < 2 || c < 2) return 0;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        p[y][x] = pxv(r - 2 + y, c - 2 + x);
    gx = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    m = gx + gy;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic check_out(input logic en);
    exp_t e;
    if (en && exp_q.size() > 0 && exp_q[0].due <= ena_cnt) begin
      e = exp_q.pop_front();
      chk("edge_valid", edge_valid, 1);
      chk("edge_out", edge_out, e.out);
      chk("edge_bin", edge_bin, e.bin);
      chk("frame_done", frame_done, e.fd);
      if (edge_valid === 1'b1) begin
        n_res++;
        if (edge_out == 8'd255) n_sat++;
        if (edge_out == 8'd40)  n_40++;
        if (edge_out == 8'd200) n_200++;
        if (edge_bin === 1'b1)  n_bin++;
      end
    end else begin
      chk("idle_valid", edge_valid, 0);
      chk("idle_frame_done", frame_done, 0);
    end
    if (frame_done === 1'b1) n_fd++;
  endtask

  // One clock: drive inputs, predict, clock, then check
  task automatic step(input logic en, input logic pv, input logic vs, input logic [7:0] px);
    logic rise, acc;
    exp_t e;
    int   em;
    enable = en; pixel_valid = pv; vsync = vs; pixel_in = px;
    rise = vs && !m_vprev;
    acc  = en && pv && !rise && !m_full;
    if (en) ena_cnt++;
    if (rise) begin
      exp_q.delete();
      m_row = 0; m_col = 0; m_full = 1'b0;
    end
    if (acc) begin
      em    = exp_mag(m_row, m_col);
      e.out = 8'(em);
      e.bin = (m_row >= 2 && m_col >= 2 && em >= thr);
      e.fd  = (m_row == H-1 && m_col == W-1);
      e.due = ena_cnt + 2;
      exp_q.push_back(e);
      if (m_col == W-1) begin
        m_col = 0;
        if (m_row == H-1) begin m_row = 0; m_full = 1'b1; end
        else m_row++;
      end else m_col++;
    end
    m_vprev = vs;
    @(posedge clk); #1;
    check_out(en);
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 8'(pxv(m_row, m_col)));
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic vsync_pulse();
    step(1'b1, 1'b0, 1'b1, 8'd0);
    step(1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic phase_begin(input int mode, input int l, input int h, input int t);
    img_mode = mode; lo = l; hi = h; thr = t; threshold = 8'(t);
    n_res = 0; n_sat = 0; n_fd = 0; n_bin = 0; n_40 = 0; n_200 = 0;
  endtask

  task automatic phase_end(input string tag, input int e_res, input int e_sat, input int e_fd);
    chk({tag, "_results"}, n_res, e_res);
    chk({tag, "_sat255"}, n_sat, e_sat);
    chk({tag, "_frame_done"}, n_fd, e_fd);
    chk({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; pixel_valid = 1'b0; vsync = 1'b0;
    pixel_in = 8'd0; threshold = 8'd128;
    m_row = 0; m_col = 0; m_full = 1'b0; m_vprev = 1'b0; ena_cnt = 0;
    phase_begin(0, 80, 80, 128);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_edge_out", edge_out, 0);
    chk("rst_edge_bin", edge_bin, 0);
    chk("rst_edge_valid", edge_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    rst = 1'b0;

    // Flat frame plus over-length input: 32 results, all zero, one frame_done
    phase_begin(0, 80, 80, 128);
    feed(W*H + 5);
    drain();
    phase_end("flat", W*H, 0, 1);
    chk("flat_bin", n_bin, 0);

    // Vertical step 0 -> 100: saturated edges at cols 4,5 of rows 2,3
    vsync_pulse();
    phase_begin(0, 0, 100, 128);
    feed(W*H);
    drain();
    phase_end("vstep", W*H, 4, 1);
    chk("vstep_bin", n_bin, 4);

    // Gentle step 0 -> 10: magnitude 40, below threshold 128
    vsync_pulse();
    phase_begin(0, 0, 10, 128);
    feed(W*H);
    drain();
    phase_end("gentle", W*H, 0, 1);
    chk("gentle_40", n_40, 4);
    chk("gentle_bin", n_bin, 0);

    // Same frame with threshold 40: equality sets the flag
    vsync_pulse();
    phase_begin(0, 0, 10, 40);
    feed(W*H);
    drain();
    phase_end("gentle_t40", W*H, 0, 1);
    chk("gentle_t40_bin", n_bin, 4);

    // Gapped vertical step: valid bubbles and a 5-cycle disable mid-line
    vsync_pulse();
    phase_begin(0, 0, 100, 128);
    for (int i = 0; i < W*H; i++) begin
      if (i == 13)
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0, 8'(pxv(m_row, m_col)));
      step(1'b1, 1'b1, 1'b0, 8'(pxv(m_row, m_col)));
      if (i % 2 == 1) step(1'b1, 1'b0, 1'b0, 8'd0);
    end
    drain();
    phase_end("gapped", W*H, 4, 1);

    // Horizontal step 0 -> 50 at row 2: Gy-only magnitude 200
    vsync_pulse();
    phase_begin(1, 0, 50, 128);
    feed(W*H);
    drain();
    phase_end("hstep", W*H, 0, 1);
    chk("hstep_200", n_200, 12);
    chk("hstep_bin", n_bin, 12);

    // Mid-frame vsync squashes in-flight results, then a flat frame
    vsync_pulse();
    phase_begin(0, 0, 100, 128);
    feed(29);
    step(1'b1, 1'b1, 1'b1, 8'd100);
    chk("squash_valid_0", edge_valid, 0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0, 1'b0, 8'd0);
      chk("squash_valid", edge_valid, 0);
    end
    phase_begin(0, 80, 80, 128);
    feed(W*H);
    drain();
    phase_end("after_vsync", W*H, 0, 1);

    // Reset mid-line while a saturated result is on the outputs
    vsync_pulse();
    phase_begin(0, 0, 100, 128);
    feed(23);
    chk("pre_rst_edge_out", edge_out, 255);
    rst = 1'b1;
    #1;
    chk("mid_rst_edge_out", edge_out, 0);
    chk("mid_rst_edge_bin", edge_bin, 0);
    chk("mid_rst_edge_valid", edge_valid, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    @(posedge clk); #1;
    rst = 1'b0; vsync = 1'b0;
    exp_q.delete();
    m_row = 0; m_col = 0; m_full = 1'b0; m_vprev = 1'b0;
    phase_begin(0, 0, 100, 128);
    feed(W*H);
    drain();
    phase_end("post_rst", W*H, 4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
